// File: rtl/branch_predictor_pkg.sv
// bp_pkg: shared types and constants for the branch predictor.
// Provides kind_t (control-transfer class), 2-bit counter values, and idx_w() to size the BTB index.
package bp_pkg;
    typedef enum logic [1:0] {BR = 2'd0, JAL = 2'd1, JALR = 2'd2, RET = 2'd3} kind_t;
    localparam logic [1:0] CTR_SNT = 2'd0;
    localparam logic [1:0] CTR_WNT = 2'd1;
    localparam logic [1:0] CTR_WT  = 2'd2;
    localparam logic [1:0] CTR_ST  = 2'd3;
    function automatic int idx_w(input int entries);
        return $clog2(entries);
    endfunction
endpackage

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch-lookup and resolve-update bus of the branch predictor.
// Signal suffixes are from the predictor's view.
// Ports:
//   lookup_pc_i -> pred_hit_o / pred_taken_o / pred_target_o (same cycle),
//   upd_* resolved control transfer, flush_i BTB invalidate.
// Modports:
//   master drives lookups and updates (core side).
//   slave is the predictor.
interface branch_predictor_if #(parameter int XLEN = 32);
    import bp_pkg::*;
    logic [XLEN-1:0] lookup_pc_i;
    logic            pred_hit_o;
    logic            pred_taken_o;
    logic [XLEN-1:0] pred_target_o;
    logic            upd_valid_i;
    logic [XLEN-1:0] upd_pc_i;
    logic [XLEN-1:0] upd_target_i;
    logic            upd_taken_i;
    kind_t           upd_kind_i;
    logic            upd_call_i;
    logic            flush_i;
    modport master (
        output lookup_pc_i, upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i, upd_kind_i, upd_call_i, flush_i,
        input  pred_hit_o, pred_taken_o, pred_target_o
    );
    modport slave (
        input  lookup_pc_i, upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i, upd_kind_i, upd_call_i, flush_i,
        output pred_hit_o, pred_taken_o, pred_target_o
    );
endinterface

// File: rtl/branch_predictor_ras.sv
// bp_ras: circular return-address stack.
// Ports:
//   clk_i, rst_i (async, active-low),
//   push/push_data, pop,
//   top (most recent entry), empty.
// Push when full overwrites the oldest entry.
// Pop when empty is ignored.
// Pop+push replaces the top.
module bp_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty
);
    localparam int PW = $clog2(RAS_DEPTH);
    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   tidx;
    logic [PW-1:0]   widx;
    logic [PW:0]     cnt;
    logic            do_pop;
    assign empty  = cnt == '0;
    assign do_pop = pop && !empty;
    assign tidx   = ptr - 1'b1;
    assign top    = mem[tidx];
    // pop-then-push writes over the current top instead of the free slot
    assign widx   = do_pop ? tidx : ptr;
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ptr <= '0;
            cnt <= '0;
        end else if (push && do_pop) begin
            ptr <= ptr;
        end else if (push) begin
            ptr <= ptr + 1'b1;
            cnt <= cnt == (PW+1)'(RAS_DEPTH) ? cnt : cnt + 1'b1;
        end else if (do_pop) begin
            ptr <= tidx;
            cnt <= cnt - 1'b1;
        end
    end
    always_ff @(posedge clk_i) begin
        if (push) mem[widx] <= push_data;
    end
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters and optional return-address stack.
// Ports:
//   clk_i, rst_i (async, active-low),
//   bp (branch_predictor_if.slave: lookup/prediction and resolve-update).
// Config: define BP_RAS_EN to predict RET targets from a return-address stack (bp_ras).
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ENTRIES   = 16,
    parameter int TAG_W     = 8,
    parameter int RAS_DEPTH = 4
) (
    input logic               clk_i,
    input logic               rst_i,
    branch_predictor_if.slave bp
);
    localparam int IDX_W = idx_w(ENTRIES);
    logic             v   [ENTRIES];
    logic [TAG_W-1:0] tg  [ENTRIES];
    logic [XLEN-1:0]  tgt [ENTRIES];
    logic [1:0]       ctr [ENTRIES];
    kind_t            knd [ENTRIES];
    logic [IDX_W-1:0] li, ui;
    logic [TAG_W-1:0] lt, ut;
    logic             hit, uhit, wr;
    logic [1:0]       nctr;
    logic [XLEN-1:0]  target_raw;
    assign li   = bp.lookup_pc_i[IDX_W+1:2];
    assign lt   = bp.lookup_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign ui   = bp.upd_pc_i[IDX_W+1:2];
    assign ut   = bp.upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign hit  = v[li] && tg[li] == lt;
    assign uhit = v[ui] && tg[ui] == ut;
    // not-taken misses never allocate; flush wins over any update
    assign wr   = bp.upd_valid_i && (uhit || bp.upd_taken_i) && !bp.flush_i;
    assign nctr = bp.upd_kind_i != BR ? CTR_ST :
                  !uhit               ? CTR_WT :
                  bp.upd_taken_i      ? (ctr[ui] == CTR_ST  ? CTR_ST  : ctr[ui] + 2'd1) :
                                        (ctr[ui] == CTR_SNT ? CTR_SNT : ctr[ui] - 2'd1);
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                v[i]   <= 1'b0;
                tg[i]  <= '0;
                tgt[i] <= '0;
                ctr[i] <= CTR_WNT;
                knd[i] <= BR;
            end
        end else if (bp.flush_i) begin
            for (int i = 0; i < ENTRIES; i++) v[i] <= 1'b0;
        end else if (wr) begin
            v[ui]   <= 1'b1;
            tg[ui]  <= ut;
            tgt[ui] <= bp.upd_target_i;
            ctr[ui] <= nctr;
            knd[ui] <= bp.upd_kind_i;
        end
    end
`ifdef BP_RAS_EN
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;
    bp_ras #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (bp.upd_valid_i && bp.upd_call_i && !bp.flush_i),
        .pop       (bp.upd_valid_i && bp.upd_kind_i == RET && !bp.flush_i),
        .push_data (bp.upd_pc_i + XLEN'(4)),
        .top       (ras_top),
        .empty     (ras_empty)
    );
    assign target_raw = knd[li] == RET && !ras_empty ? ras_top : tgt[li];
`else
    assign target_raw = tgt[li];
`endif
    assign bp.pred_hit_o    = hit;
    assign bp.pred_taken_o  = hit && (ctr[li][1] || knd[li] != BR);
    assign bp.pred_target_o = bp.pred_taken_o ? target_raw : '0;
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed scoreboard bench for branch_predictor (ENTRIES=16, TAG_W=8, RAS_DEPTH=4).
module tb_branch_predictor;
    import bp_pkg::*;
    typedef struct {
        string       name;
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
    } exp_t;
`ifdef BP_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic chk = 1'b0;
    exp_t q[$];
    exp_t e;
    int n_chk = 0;
    int n_fail = 0;
    always #5 clk = ~clk;

    branch_predictor_if #(.XLEN(32)) bus();
    branch_predictor #(.XLEN(32), .ENTRIES(16), .TAG_W(8), .RAS_DEPTH(4)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bp    (bus)
    );

    // monitor: compares the presented prediction against the oldest expectation
    always @(negedge clk) begin
        if (chk) begin
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL monitor: prediction presented with no expectation queued");
            end else begin
                e = q.pop_front();
                if (bus.pred_hit_o !== e.hit || bus.pred_taken_o !== e.taken || bus.pred_target_o !== e.tgt) begin
                    n_fail++;
                    $display("FAIL %s: got hit=%0b taken=%0b target=%h, expected hit=%0b taken=%0b target=%h",
                             e.name, bus.pred_hit_o, bus.pred_taken_o, bus.pred_target_o, e.hit, e.taken, e.tgt);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk, input kind_t k, input logic call);
        bus.upd_valid_i  = 1'b1;
        bus.upd_pc_i     = pc;
        bus.upd_target_i = tgt;
        bus.upd_taken_i  = tk;
        bus.upd_kind_i   = k;
        bus.upd_call_i   = call;
    endtask

    task automatic idle_upd;
        bus.upd_valid_i = 1'b0;
        bus.flush_i     = 1'b0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk, input kind_t k, input logic call);
        drive_upd(pc, tgt, tk, k, call);
        tick();
        idle_upd();
    endtask

    // starts at posedge+1, samples at the following negedge, returns at the next posedge+1
    task automatic look(input string nm, input logic [31:0] pc, input logic h, input logic t, input logic [31:0] tg);
        bus.lookup_pc_i = pc;
        q.push_back('{name: nm, hit: h, taken: t, tgt: tg});
        chk = 1'b1;
        @(negedge clk);
        #1 chk = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.lookup_pc_i  = '0;
        bus.upd_pc_i     = '0;
        bus.upd_target_i = '0;
        bus.upd_taken_i  = 1'b0;
        bus.upd_kind_i   = BR;
        bus.upd_call_i   = 1'b0;
        idle_upd();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        look("reset_lookup", 32'h100, 0, 0, 32'h0);

        upd(32'h40, 32'h80, 1, BR, 0);
        look("br_alloc", 32'h40, 1, 1, 32'h80);
        upd(32'h40, 32'h80, 0, BR, 0);
        look("br_dec_wnt", 32'h40, 1, 0, 32'h0);
        repeat (3) upd(32'h40, 32'h80, 1, BR, 0);
        look("br_sat_st", 32'h40, 1, 1, 32'h80);
        upd(32'h40, 32'h80, 0, BR, 0);
        look("br_st_to_wt", 32'h40, 1, 1, 32'h80);
        repeat (3) upd(32'h40, 32'h80, 0, BR, 0);
        look("br_sat_snt", 32'h40, 1, 0, 32'h0);
        upd(32'h40, 32'h80, 1, BR, 0);
        look("br_snt_to_wnt", 32'h40, 1, 0, 32'h0);

        upd(32'h80, 32'h123, 1, BR, 0);
        look("alias_old_miss", 32'h40, 0, 0, 32'h0);
        look("alias_new_hit", 32'h80, 1, 1, 32'h123);
        upd(32'hC0, 32'h456, 0, BR, 0);
        look("nt_miss_no_alloc", 32'hC0, 0, 0, 32'h0);
        look("nt_miss_keeps", 32'h80, 1, 1, 32'h123);

        bus.flush_i = 1'b1;
        tick();
        idle_upd();
        drive_upd(32'h40, 32'h80, 1, BR, 0);
        look("same_cycle_old", 32'h40, 0, 0, 32'h0);
        idle_upd();
        look("same_cycle_new", 32'h40, 1, 1, 32'h80);

        upd(32'h900, 32'hA00, 1, RET, 0);
        for (int i = 1; i <= 5; i++) upd(i * 32'h100, 32'h1000, 0, JAL, 1);
        look("ras_top_504", 32'h900, 1, 1, RAS ? 32'h504 : 32'hA00);
        upd(32'h900, 32'hA00, 1, RET, 0);
        look("ras_top_404", 32'h900, 1, 1, RAS ? 32'h404 : 32'hA00);
        upd(32'h900, 32'hA00, 1, RET, 0);
        look("ras_top_304", 32'h900, 1, 1, RAS ? 32'h304 : 32'hA00);
        upd(32'h900, 32'hA00, 1, RET, 0);
        look("ras_top_204", 32'h900, 1, 1, RAS ? 32'h204 : 32'hA00);
        upd(32'h900, 32'hA00, 1, RET, 0);
        look("ras_empty_btb", 32'h900, 1, 1, 32'hA00);

        bus.flush_i = 1'b1;
        drive_upd(32'h140, 32'h200, 1, BR, 0);
        tick();
        idle_upd();
        look("flush_900", 32'h900, 0, 0, 32'h0);
        look("flush_140", 32'h140, 0, 0, 32'h0);
        look("flush_80", 32'h80, 0, 0, 32'h0);

        upd(32'h44, 32'h300, 1, JAL, 0);
        look("jal_alloc", 32'h44, 1, 1, 32'h300);
        rst_n = 1'b0;
        look("async_reset", 32'h44, 0, 0, 32'h0);
        rst_n = 1'b1;
        look("after_reset", 32'h44, 0, 0, 32'h0);

        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, 0 required", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
